tdm_port: RTL and testbench
===========================

Name: tdm_port

Overview:
- Parametrised multi-channel serial audio port: merges clock/frame generation, transmit serializer and receive deserializer for NCH slots per frame.
- Supports I2S (50% frame clock, 1-bit delay) and TDM pulse-sync formats, plus an internal loopback.
- Sits between the sample FIFOs/DSP datapath and the codec pins.
- Successor to the fixed 2-channel I2S port and clock generator pair.

Parameters:
- DW, 24: sample width in bits.
- SW, 32: slot width in sclk bits; DW+DELAY <= SW.
- NCH, 2: slots per frame; even, >= 2.
- CLKDIV, 8: clk cycles per sclk period; even, >= 4.
- DELAY, 1: sclk bits from slot start to MSB; 1 = I2S, 0 = left-justified/TDM.
- FS_PULSE, 0: 0 = 50% duty fs (low during first NCH/2 slots); 1 = fs high for bit 0 of the frame only.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tx_data  in  NCH*DW  frame samples; slot k occupies bits [k*DW +: DW]
- tx_rd_en  out  1  one-cycle request for the next frame
- tx_rd_valid  in  1  tx_data valid; sampled exactly 1 clk after tx_rd_en
- tx_underflow  out  1  one-cycle pulse when tx_rd_valid was low at the sample point
- rx_data  out  NCH*DW  received frame, same packing as tx_data
- rx_valid  out  1  one-cycle pulse when rx_data is updated
- loopback  in  1  1 = receiver takes sdo internally and ignores sdi
- sclk  out  1  serial bit clock
- fs  out  1  frame sync / lrclk
- sdo  out  1  serial data out
- sdi  in  1  serial data in

Behaviour:
- Reset values:
  - Outputs: sclk=0, fs=0, sdo=0, tx_rd_en=0, tx_underflow=0, rx_data=0, rx_valid=0.
  - Internal state: div_cnt=0, bit_cnt=0, shadow and shift registers 0.
  - Reset asserted mid-frame aborts the frame immediately.
- Counters:
  - div_cnt counts 0..CLKDIV-1, then wraps.
  - fall tick = div_cnt==0; rise tick = div_cnt==CLKDIV/2.
  - sclk is low for div_cnt < CLKDIV/2, high otherwise, registered.
  - bit_cnt advances 0..NCH*SW-1 on each fall tick and wraps.
- fs, updated on fall ticks:
  - FS_PULSE=0: fs=1 when bit_cnt >= (NCH/2)*SW.
  - FS_PULSE=1: fs=1 only when bit_cnt==0.
- TX path:
  - On the fall tick with bit_cnt==0, the shadow register loads the shift register.
  - sdo on fall ticks:
    - bit_cnt = k*SW + DELAY + i (0 <= i < DW) drives slot k bit DW-1-i (MSB first).
    - All other bit positions drive 0.
- Fetch:
  - tx_rd_en pulses for 1 clk on the fall tick where bit_cnt becomes NCH*SW-1.
  - On the next clk, if tx_rd_valid=1, tx_data is captured into shadow.
  - Otherwise shadow is cleared to 0 and tx_underflow pulses in that same cycle.
  - The first frame after reset transmits zeros. The first tx_rd_en occurs at the end of the first frame.
- RX path:
  - sdi_int = loopback ? sdo : sdi.
  - Sampled on rise ticks into slot k, bit DW-1-i, using the same bit_cnt mapping as TX.
  - After the rise tick sampling slot NCH-1 bit 0, the assembled frame is copied to rx_data and rx_valid pulses 1 clk later, exactly once per frame.
  - Non-data bits are ignored.
- Loopback latency:
  - With loopback=1, the frame loaded at frame N appears on rx_data during frame N.
  - Frame N = the frame fetched by the tx_rd_en at the end of frame N-1.
- Simultaneous events:
  - tx_rd_en never coincides with rx_valid unless (NCH-1)*SW+DELAY+DW-1 == NCH*SW-1. Both are then legal and independent.
- Widths:
  - bit_cnt is $clog2(NCH*SW) bits.
  - div_cnt is $clog2(CLKDIV) bits.
- Invalid parameters: illegal combinations (odd NCH, odd CLKDIV, DW+DELAY > SW) cause an elaboration-time fatal error.

Decomposition:
- Package tdm_pkg:
  - fs format enum (FS_HALF, FS_PULSE).
  - Function frame_bits(NCH,SW).
  - Function slot_bit(bit_cnt) returning slot index, bit index and data-valid flag.
  - Parameter legality-check function.
- Sub-module tdm_clkgen: div_cnt, bit_cnt, sclk, fs, fall/rise tick strobes, bit_cnt output.
- tdm_port instantiates tdm_clkgen; TX/RX shifting stays in tdm_port.

Test Plan:
- Reset, then run 1 frame with defaults:
  - sclk period = 8 clk.
  - fs low for 32 sclk, high for 32.
  - sdo all 0.
  - tx_rd_en pulses once at bit_cnt 63.
- Defaults, loopback=1, tx_rd_valid=1, tx_data={24'hA5A5A5 (R), 24'h123456 (L)}:
  - Next frame sdo shows 24'h123456 MSB-first starting at bit_cnt 1.
  - rx_valid pulses and rx_data equals tx_data.
- NCH=8, SW=32, DW=24, DELAY=0, FS_PULSE=1, loopback=1, slots 24'h000001..24'h000008:
  - fs is high only for bit 0.
  - rx_data returns all 8 slots.
  - Exactly one rx_valid per 256-bit frame.
- tx_rd_valid=0 at one fetch:
  - tx_underflow pulses 1 clk after tx_rd_en.
  - That frame sdo = all zeros.
  - The following frame with valid data resumes correctly.
- loopback=0, sdi driven externally with 24'hFFFFFF in slot 0 and 0 elsewhere:
  - rx_data slot 0 = 24'hFFFFFF, slot 1 = 0.
  - Changing sdo data has no effect on rx_data.
- Assert rst mid-frame (bit_cnt=20) for 3 clk:
  - All outputs return to reset values asynchronously.
  - The following frame restarts at bit_cnt 0 transmitting zeros, with no spurious rx_valid before the first full frame.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM/I2S serial audio port.
// Covers frame geometry, the bit-position to slot/bit mapping and the parameter legality check.
package tdm_pkg;

    typedef enum logic {
        FS_HALF  = 1'b0,
        FS_PULSE = 1'b1
    } fs_fmt_e;

    typedef struct packed {
        logic [15:0] slot;
        logic [15:0] bidx;
        logic        valid;
    } slot_bit_t;

    function automatic int frame_bits(input int nch, input int sw);
        return nch * sw;
    endfunction

    // Maps a frame bit position to the sample bit it carries; MSB comes DELAY bits into the slot.
    function automatic slot_bit_t slot_bit(input int bc, input int sw, input int dw, input int delay);
        slot_bit_t r;
        int        off;
        off     = bc % sw;
        r.slot  = 16'(bc / sw);
        r.valid = (off >= delay) && (off < delay + dw);
        r.bidx  = r.valid ? 16'(dw - 1 - (off - delay)) : 16'd0;
        return r;
    endfunction

    function automatic bit params_ok(input int dw, input int sw, input int nch,
                                     input int clkdiv, input int delay);
        return (nch >= 2) && (nch % 2 == 0) && (clkdiv >= 4) && (clkdiv % 2 == 0) &&
               (dw >= 1) && (delay >= 0) && (dw + delay <= sw);
    endfunction

endpackage

// File: rtl/tdm_clkgen.sv
// Bit clock and frame sync generator: divides clk into sclk, counts frame bits and drives fs.
// bit_nxt is the bit position that becomes current on the coming fall tick.
module tdm_clkgen
    import tdm_pkg::*;
#(
    parameter int      SW     = 32,
    parameter int      NCH    = 2,
    parameter int      CLKDIV = 8,
    parameter fs_fmt_e FMT    = FS_HALF,
    localparam int     FB     = frame_bits(NCH, SW),
    localparam int     BW     = $clog2(FB),
    localparam int     DVW    = $clog2(CLKDIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          sclk,
    output logic          fs,
    output logic          fall,
    output logic          rise,
    output logic [BW-1:0] bit_cnt,
    output logic [BW-1:0] bit_nxt
);

    logic [DVW-1:0] div_cnt_reg;
    logic [BW-1:0]  bit_cnt_reg;
    logic           run_reg;
    logic           sclk_reg;
    logic           fs_reg;
    logic           fs_next;

    assign fall    = (div_cnt_reg == '0);
    assign rise    = (div_cnt_reg == DVW'(CLKDIV / 2));
    assign sclk    = sclk_reg;
    assign fs      = fs_reg;
    assign bit_cnt = bit_cnt_reg;

    // The very first fall tick after reset presents bit 0 rather than advancing past it.
    always_comb begin
        bit_nxt = bit_cnt_reg;
        if (run_reg) begin
            bit_nxt = (bit_cnt_reg == BW'(FB - 1)) ? '0 : bit_cnt_reg + 1'b1;
        end
        fs_next = (FMT == FS_PULSE) ? (bit_nxt == '0) : (bit_nxt >= BW'((NCH / 2) * SW));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            run_reg     <= 1'b0;
            sclk_reg    <= 1'b0;
            fs_reg      <= 1'b0;
        end else begin
            div_cnt_reg <= (div_cnt_reg == DVW'(CLKDIV - 1)) ? '0 : div_cnt_reg + 1'b1;
            sclk_reg    <= (div_cnt_reg >= DVW'(CLKDIV / 2));
            if (fall) begin
                run_reg     <= 1'b1;
                bit_cnt_reg <= bit_nxt;
                fs_reg      <= fs_next;
            end
        end
    end

endmodule

// File: rtl/tdm_port.sv
// Multi-slot serial audio port: frame fetch, TX serializer and RX deserializer around tdm_clkgen.
// sdo changes on sclk falling edges; sdi (or sdo in loopback) is sampled on sclk rising edges.
module tdm_port
    import tdm_pkg::*;
#(
    parameter int DW       = 24,
    parameter int SW       = 32,
    parameter int NCH      = 2,
    parameter int CLKDIV   = 8,
    parameter int DELAY    = 1,
    parameter int FS_PULSE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH*DW-1:0] tx_data,
    output logic            tx_rd_en,
    input  logic            tx_rd_valid,
    output logic            tx_underflow,
    output logic [NCH*DW-1:0] rx_data,
    output logic            rx_valid,
    input  logic            loopback,
    output logic            sclk,
    output logic            fs,
    output logic            sdo,
    input  logic            sdi
);

    localparam int      FW  = NCH * DW;
    localparam int      FB  = frame_bits(NCH, SW);
    localparam int      BW  = $clog2(FB);
    localparam int      IW  = $clog2(FW);
    localparam fs_fmt_e FMT = fs_fmt_e'(FS_PULSE != 0);

    generate
        if (!params_ok(DW, SW, NCH, CLKDIV, DELAY)) begin : g_bad_params
            $fatal(1, "tdm_port: illegal parameter combination");
        end
    endgenerate

    logic          fall;
    logic          rise;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;

    tdm_clkgen #(
        .SW     (SW),
        .NCH    (NCH),
        .CLKDIV (CLKDIV),
        .FMT    (FMT)
    ) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .fs      (fs),
        .fall    (fall),
        .rise    (rise),
        .bit_cnt (bit_cnt),
        .bit_nxt (bit_nxt)
    );

    logic [FW-1:0] tx_shadow_reg;
    logic [FW-1:0] tx_shift_reg;
    logic [FW-1:0] rx_shift_reg;
    logic [FW-1:0] rx_data_reg;
    logic          sdo_reg;
    logic          tx_rd_en_reg;
    logic          tx_underflow_reg;
    logic          rx_done_reg;
    logic          rx_valid_reg;

    slot_bit_t     tx_sb;
    slot_bit_t     rx_sb;
    logic [FW-1:0] tx_src;
    logic [IW-1:0] tx_idx;
    logic [IW-1:0] rx_idx;
    logic          rx_last;
    logic          sdi_int;

    assign sdi_int = loopback ? sdo_reg : sdi;

    // At bit 0 the shift register is being loaded on this same edge, so read the shadow directly.
    always_comb begin
        tx_sb   = slot_bit(int'(bit_nxt), SW, DW, DELAY);
        rx_sb   = slot_bit(int'(bit_cnt), SW, DW, DELAY);
        tx_idx  = IW'(int'(tx_sb.slot) * DW + int'(tx_sb.bidx));
        rx_idx  = IW'(int'(rx_sb.slot) * DW + int'(rx_sb.bidx));
        tx_src  = (bit_nxt == '0) ? tx_shadow_reg : tx_shift_reg;
        rx_last = rx_sb.valid && (rx_sb.slot == 16'(NCH - 1)) && (rx_sb.bidx == 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shadow_reg    <= '0;
            tx_shift_reg     <= '0;
            rx_shift_reg     <= '0;
            rx_data_reg      <= '0;
            sdo_reg          <= 1'b0;
            tx_rd_en_reg     <= 1'b0;
            tx_underflow_reg <= 1'b0;
            rx_done_reg      <= 1'b0;
            rx_valid_reg     <= 1'b0;
        end else begin
            tx_rd_en_reg     <= fall && (bit_nxt == BW'(FB - 1));
            tx_underflow_reg <= 1'b0;
            if (tx_rd_en_reg) begin
                if (tx_rd_valid) begin
                    tx_shadow_reg <= tx_data;
                end else begin
                    tx_shadow_reg    <= '0;
                    tx_underflow_reg <= 1'b1;
                end
            end

            if (fall) begin
                if (bit_nxt == '0) begin
                    tx_shift_reg <= tx_shadow_reg;
                end
                sdo_reg <= tx_sb.valid ? tx_src[tx_idx] : 1'b0;
            end

            rx_done_reg <= 1'b0;
            if (rise && rx_sb.valid) begin
                rx_shift_reg[rx_idx] <= sdi_int;
                rx_done_reg          <= rx_last;
            end
            rx_valid_reg <= rx_done_reg;
            if (rx_done_reg) begin
                rx_data_reg <= rx_shift_reg;
            end
        end
    end

    assign sdo          = sdo_reg;
    assign tx_rd_en     = tx_rd_en_reg;
    assign tx_underflow = tx_underflow_reg;
    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;

endmodule

// File: tb/tb_tdm_port.sv
// Directed bench for tdm_port: default I2S instance (u0) and an 8-slot pulse-sync TDM instance (u1).
`timescale 1ns/1ps
module tb_tdm_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u0: defaults (DW=24, SW=32, NCH=2, CLKDIV=8, DELAY=1, FS_PULSE=0)
    logic        rst0 = 1'b1;
    logic [47:0] tx_data0 = '0;
    logic        tx_rd_en0, tx_underflow0, rx_valid0, sclk0, fs0, sdo0, sdi0;
    logic        tx_rd_valid0 = 1'b0;
    logic        loopback0 = 1'b0;
    logic [47:0] rx_data0;

    // u1: NCH=8, DELAY=0, FS_PULSE=1
    logic         rst1 = 1'b1;
    logic [191:0] tx_data1 = '0;
    logic         tx_rd_en1, tx_underflow1, rx_valid1, sclk1, fs1, sdo1;
    logic         tx_rd_valid1 = 1'b0;
    logic         loopback1 = 1'b0;
    logic         sdi1 = 1'b0;
    logic [191:0] rx_data1;

    tdm_port u0 (
        .clk(clk), .rst(rst0), .tx_data(tx_data0), .tx_rd_en(tx_rd_en0),
        .tx_rd_valid(tx_rd_valid0), .tx_underflow(tx_underflow0), .rx_data(rx_data0),
        .rx_valid(rx_valid0), .loopback(loopback0), .sclk(sclk0), .fs(fs0),
        .sdo(sdo0), .sdi(sdi0)
    );

    tdm_port #(.DW(24), .SW(32), .NCH(8), .CLKDIV(8), .DELAY(0), .FS_PULSE(1)) u1 (
        .clk(clk), .rst(rst1), .tx_data(tx_data1), .tx_rd_en(tx_rd_en1),
        .tx_rd_valid(tx_rd_valid1), .tx_underflow(tx_underflow1), .rx_data(rx_data1),
        .rx_valid(rx_valid1), .loopback(loopback1), .sclk(sclk1), .fs(fs1),
        .sdo(sdo1), .sdi(sdi1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Serial bit expected at frame position b of a 2x24-in-32 I2S frame (MSB one bit into the slot).
    function automatic logic ser_bit(input logic [47:0] w, input int b);
        int          off;
        logic [47:0] t;
        off = b % 32;
        if (off < 1 || off > 24) return 1'b0;
        t = w >> ((b / 32) * 24 + 24 - off);
        return t[0];
    endfunction

    // External codec model for u0: sdi presents bit position rcnt0 between sclk rising edges.
    logic [47:0] sdi_pat0 = '0;
    int          rcnt0 = 0;
    always @(posedge sclk0 or posedge rst0) begin
        if (rst0) rcnt0 <= 0;
        else      rcnt0 <= (rcnt0 + 1) % 64;
    end
    assign sdi0 = ser_bit(sdi_pat0, rcnt0);

    logic prev0 = 1'b0, rise0 = 1'b0;
    logic prev1 = 1'b0, rise1 = 1'b0;

    task automatic step0();
        @(negedge clk);
        rise0 = sclk0 && !prev0;
        prev0 = sclk0;
    endtask

    task automatic step1();
        @(negedge clk);
        rise1 = sclk1 && !prev1;
        prev1 = sclk1;
    endtask

    // Runs u0 until the next tx_rd_en; captures sdo per bit position and the rx_valid events.
    task automatic run_frame0(input int start, output int nval, output logic [47:0] rxw,
                              output logic [63:0] cap, output logic found, output int vbit);
        int b;
        b     = start;
        nval  = 0;
        rxw   = '0;
        cap   = '0;
        found = 1'b0;
        vbit  = -1;
        for (int c = 0; c < 700; c++) begin
            step0();
            if (rise0) begin
                cap = cap | (64'(sdo0) << b);
                b   = (b + 1) % 64;
            end
            if (rx_valid0) begin
                nval++;
                rxw  = rx_data0;
                vbit = b;
            end
            if (tx_rd_en0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [47:0] tx;
        logic        valid;
        logic        lb;
        logic [47:0] sdi;
        logic [47:0] exp_rx;
        logic        exp_uf;
    } vec_t;

    vec_t         vecs [6];
    int           rises, fs_low, sdo_ones, first_cyc, period, nval, vbit, b1, fs_hi, fs_hi_bit;
    logic         found;
    logic [47:0]  rxw;
    logic [63:0]  cap, exp_sdo;
    logic [191:0] rxw1, exp1;

    initial begin
        //           tx                   valid lb    sdi                  exp_rx               uf
        vecs[0] = '{48'hA5A5A5_123456, 1'b1, 1'b1, 48'h0,              48'hA5A5A5_123456, 1'b0};
        vecs[1] = '{48'hDEADBE_EF0123, 1'b0, 1'b1, 48'h0,              48'h000000_000000, 1'b1};
        vecs[2] = '{48'hFEDCBA_800001, 1'b1, 1'b1, 48'h0,              48'hFEDCBA_800001, 1'b0};
        vecs[3] = '{48'h111111_222222, 1'b1, 1'b0, 48'h000000_FFFFFF,  48'h000000_FFFFFF, 1'b0};
        vecs[4] = '{48'h333333_444444, 1'b1, 1'b0, 48'h000000_FFFFFF,  48'h000000_FFFFFF, 1'b0};
        vecs[5] = '{48'h7FFFFF_C00003, 1'b1, 1'b1, 48'h0,              48'h7FFFFF_C00003, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check_int("rst sclk", int'(sclk0), 0);
        check_int("rst fs", int'(fs0), 0);
        check_int("rst sdo", int'(sdo0), 0);
        check_int("rst tx_rd_en", int'(tx_rd_en0), 0);
        check_int("rst underflow", int'(tx_underflow0), 0);
        check_vec("rst rx_data", 192'(rx_data0), 192'(0));
        check_int("rst rx_valid", int'(rx_valid0), 0);

        // First frame: sclk period, fs duty, silent sdo, single fetch at bit 63
        rst0 = 1'b0;
        rises = 0; fs_low = 0; sdo_ones = 0; first_cyc = 0; period = 0; found = 1'b0;
        for (int c = 0; c < 700; c++) begin
            step0();
            if (sdo0) sdo_ones++;
            if (rise0) begin
                if (rises == 0) first_cyc = c;
                else if (rises == 1) period = c - first_cyc;
                if (!fs0) fs_low++;
                rises++;
            end
            if (tx_rd_en0) begin
                found = 1'b1;
                break;
            end
        end
        check_int("frame0 fetch seen", int'(found), 1);
        check_int("frame0 sclk period", period, 8);
        check_int("frame0 fs low bits", fs_low, 32);
        check_int("frame0 fs high at end", int'(fs0), 1);
        check_int("frame0 fetch bit", rises, 63);
        check_int("frame0 sdo ones", sdo_ones, 0);

        // Table: one fetch response per entry, checked over the frame it is transmitted in
        for (int i = 0; i < 6; i++) begin
            tx_data0     = vecs[i].tx;
            tx_rd_valid0 = vecs[i].valid;
            loopback0    = vecs[i].lb;
            sdi_pat0     = vecs[i].sdi;
            step0();
            check_int($sformatf("v%0d underflow", i), int'(tx_underflow0), int'(vecs[i].exp_uf));
            check_int($sformatf("v%0d rd_en pulse", i), int'(tx_rd_en0), 0);
            tx_rd_valid0 = 1'b0;
            tx_data0     = '1;
            run_frame0(63, nval, rxw, cap, found, vbit);
            exp_sdo = '0;
            for (int b = 0; b < 64; b++)
                exp_sdo = exp_sdo | (64'(ser_bit(vecs[i].valid ? vecs[i].tx : 48'h0, b)) << b);
            check_int($sformatf("v%0d next fetch", i), int'(found), 1);
            check_int($sformatf("v%0d rx_valid count", i), nval, 1);
            check_vec($sformatf("v%0d rx_data", i), 192'(rxw), 192'(vecs[i].exp_rx));
            check_vec($sformatf("v%0d sdo frame", i), 192'(cap), 192'(exp_sdo));
            $display("vec %0d: tx=%h valid=%0d lb=%0d rx=%h", i, vecs[i].tx, vecs[i].valid,
                     vecs[i].lb, rxw);
        end

        // Reset mid-frame at bit 20 of a frame carrying all ones
        tx_data0     = '1;
        tx_rd_valid0 = 1'b1;
        loopback0    = 1'b1;
        sdi_pat0     = '0;
        b1 = 63;
        for (int c = 0; c < 700; c++) begin
            step0();
            if (rise0) begin
                if (b1 == 20) break;
                b1 = (b1 + 1) % 64;
            end
        end
        tx_rd_valid0 = 1'b0;
        check_int("midrst reached bit20", b1, 20);
        #1 rst0 = 1'b1;
        #1;
        check_int("midrst sclk", int'(sclk0), 0);
        check_int("midrst fs", int'(fs0), 0);
        check_int("midrst sdo", int'(sdo0), 0);
        check_int("midrst tx_rd_en", int'(tx_rd_en0), 0);
        check_int("midrst underflow", int'(tx_underflow0), 0);
        check_vec("midrst rx_data", 192'(rx_data0), 192'(0));
        check_int("midrst rx_valid", int'(rx_valid0), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0  = 1'b0;
        prev0 = 1'b0;
        run_frame0(0, nval, rxw, cap, found, vbit);
        check_int("postrst fetch", int'(found), 1);
        check_vec("postrst sdo zeros", 192'(cap), 192'(0));
        check_int("postrst rx_valid count", nval, 1);
        check_int("postrst rx_valid bit", vbit, 57);
        check_vec("postrst rx_data", 192'(rxw), 192'(0));

        // TDM 8-slot, pulse fs, DELAY=0, loopback
        loopback1 = 1'b1;
        rst1 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step1();
            if (tx_rd_en1) begin
                found = 1'b1;
                break;
            end
        end
        check_int("tdm first fetch", int'(found), 1);
        exp1 = '0;
        for (int k = 0; k < 8; k++) exp1 = exp1 | (192'(k + 1) << (k * 24));
        tx_data1     = exp1;
        tx_rd_valid1 = 1'b1;
        step1();
        tx_rd_valid1 = 1'b0;
        check_int("tdm underflow", int'(tx_underflow1), 0);
        b1 = 255; fs_hi = 0; fs_hi_bit = -1; nval = 0; rxw1 = '0; found = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            step1();
            if (rise1) begin
                if (fs1) begin
                    fs_hi++;
                    fs_hi_bit = b1;
                end
                b1 = (b1 + 1) % 256;
            end
            if (rx_valid1) begin
                nval++;
                rxw1 = rx_data1;
            end
            if (tx_rd_en1) begin
                found = 1'b1;
                break;
            end
        end
        check_int("tdm next fetch", int'(found), 1);
        check_int("tdm fs high bits", fs_hi, 1);
        check_int("tdm fs high position", fs_hi_bit, 0);
        check_int("tdm rx_valid count", nval, 1);
        check_vec("tdm rx_data", rxw1, exp1);
        $display("tdm frame: rx=%h", rxw1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
